// File: rtl/ntm_transformer_controller_pkg.sv
// Shared types for the transformer accelerator load/run/drain sequencer.
// Holds the FSM state, the load strobe bundle and the watchdog default.
package ntm_transformer_controller_pkg;

  localparam int TIMEOUT_CYCLES_DEF = 1024;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_B,
    LOAD_X,
    START,
    RUN
  } state_t;

  typedef struct packed {
    logic w_l;
    logic w_x;
    logic b;
    logic x;
  } strobe_t;

endpackage

// File: rtl/ntm_transformer_index_counter.sv
// Two-level column/row counter with wrap and end-of-row/end-of-matrix flags.
// Wraps back to zero after the last element, ready for the next phase.
module ntm_transformer_index_counter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         step,
  input  logic [W-1:0] cols,
  input  logic [W-1:0] rows,
  output logic         end_row,
  output logic         end_mat
);

  logic [W-1:0] col;
  logic [W-1:0] row;

  assign end_row = (col == cols - W'(1));
  assign end_mat = end_row && (row == rows - W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (step) begin
      if (end_row) begin
        col <= '0;
        row <= end_mat ? '0 : row + W'(1);
      end else begin
        col <= col + W'(1);
      end
    end
  end

endmodule

// File: rtl/ntm_transformer_controller.sv
// Load/run/drain sequencer for the transformer accelerator (W, B, X, START, H).
// Optional RUN watchdog: define NTM_TRANSFORMER_CONTROLLER_TIMEOUT_EN.
module ntm_transformer_controller
  import ntm_transformer_controller_pkg::*;
#(
  parameter int DATA_SIZE      = 64,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CTRL_START,
  output logic                 CTRL_BUSY,
  output logic                 CTRL_DONE,
  output logic                 CTRL_ERROR,
  input  logic [DATA_SIZE-1:0] CFG_SIZE_X,
  input  logic [DATA_SIZE-1:0] CFG_SIZE_L,
  input  logic                 SRC_VALID,
  output logic                 SRC_READY,
  input  logic [DATA_SIZE-1:0] SRC_DATA,
  output logic                 DST_VALID,
  output logic [DATA_SIZE-1:0] DST_DATA,
  output logic                 ACC_START,
  input  logic                 ACC_READY,
  output logic                 ACC_W_IN_L_ENABLE,
  output logic                 ACC_W_IN_X_ENABLE,
  output logic                 ACC_B_IN_ENABLE,
  output logic                 ACC_X_IN_ENABLE,
  output logic [DATA_SIZE-1:0] ACC_SIZE_X_IN,
  output logic [DATA_SIZE-1:0] ACC_SIZE_L_IN,
  output logic [DATA_SIZE-1:0] ACC_W_IN,
  output logic [DATA_SIZE-1:0] ACC_B_IN,
  output logic [DATA_SIZE-1:0] ACC_X_IN,
  input  logic                 ACC_H_OUT_ENABLE,
  input  logic [DATA_SIZE-1:0] ACC_H_OUT
);

  localparam logic [DATA_SIZE-1:0] ONE = DATA_SIZE'(1);

  state_t               state;
  strobe_t              stb;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic                 acc_start;
  logic                 rdy_seen;
  logic                 dst_valid;
  logic [DATA_SIZE-1:0] dst_data;
  logic [DATA_SIZE-1:0] opnd;
  logic [DATA_SIZE-1:0] size_x;
  logic [DATA_SIZE-1:0] size_l;
  logic [DATA_SIZE-1:0] h_cnt;

`ifdef NTM_TRANSFORMER_CONTROLLER_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] tmo;
`endif

  logic                 beat;
  logic                 accept;
  logic                 end_row;
  logic                 end_mat;
  logic [DATA_SIZE-1:0] cnt_cols;
  logic [DATA_SIZE-1:0] cnt_rows;
  logic                 h_take;
  logic                 rdy_next;
  logic [DATA_SIZE-1:0] h_next;
  logic                 finish;

  assign SRC_READY = (state == LOAD_W) || (state == LOAD_B) ||
                     (state == LOAD_X);
  assign beat      = SRC_VALID && SRC_READY;
  assign accept    = (state == IDLE) && CTRL_START &&
                     (CFG_SIZE_X != '0) && (CFG_SIZE_L != '0);

  // Vector phases reuse the matrix counter as a single row.
  always_comb begin
    cnt_cols = size_x;
    cnt_rows = size_l;
    unique case (1'b1)
      (state == LOAD_B): begin
        cnt_cols = size_l;
        cnt_rows = ONE;
      end
      (state == LOAD_X): begin
        cnt_cols = size_x;
        cnt_rows = ONE;
      end
      default: ;
    endcase
  end

  ntm_transformer_index_counter #(
    .W(DATA_SIZE)
  ) u_idx (
    .clk     (CLK),
    .rst     (RST),
    .clr     (accept),
    .step    (beat),
    .cols    (cnt_cols),
    .rows    (cnt_rows),
    .end_row (end_row),
    .end_mat (end_mat)
  );

  // Completion looks at this cycle's READY and beat so a coincident
  // final beat finishes on the very next cycle.
  assign h_take   = ACC_H_OUT_ENABLE && (h_cnt < size_l);
  assign rdy_next = rdy_seen || ACC_READY;
  assign h_next   = h_cnt + DATA_SIZE'(h_take);
  assign finish   = rdy_next && (h_next == size_l);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      stb       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      acc_start <= 1'b0;
      rdy_seen  <= 1'b0;
      dst_valid <= 1'b0;
      dst_data  <= '0;
      opnd      <= '0;
      size_x    <= '0;
      size_l    <= '0;
      h_cnt     <= '0;
`ifdef NTM_TRANSFORMER_CONTROLLER_TIMEOUT_EN
      tmo       <= '0;
`endif
    end else begin
      stb       <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      acc_start <= 1'b0;
      dst_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            size_x   <= CFG_SIZE_X;
            size_l   <= CFG_SIZE_L;
            h_cnt    <= '0;
            rdy_seen <= 1'b0;
            busy     <= 1'b1;
            state    <= LOAD_W;
          end else if (CTRL_START) begin
            error <= 1'b1;
          end
        end
        LOAD_W: begin
          if (beat) begin
            opnd    <= SRC_DATA;
            stb.w_x <= 1'b1;
            stb.w_l <= end_row;
            if (end_mat) state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (beat) begin
            opnd  <= SRC_DATA;
            stb.b <= 1'b1;
            if (end_mat) state <= LOAD_X;
          end
        end
        LOAD_X: begin
          if (beat) begin
            opnd  <= SRC_DATA;
            stb.x <= 1'b1;
            if (end_mat) state <= START;
          end
        end
        START: begin
          acc_start <= 1'b1;
          h_cnt     <= '0;
          rdy_seen  <= 1'b0;
`ifdef NTM_TRANSFORMER_CONTROLLER_TIMEOUT_EN
          tmo       <= '0;
`endif
          state     <= RUN;
        end
        RUN: begin
          rdy_seen <= rdy_next;
          if (h_take) begin
            dst_valid <= 1'b1;
            dst_data  <= ACC_H_OUT;
            h_cnt     <= h_next;
          end
          if (finish) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
`ifdef NTM_TRANSFORMER_CONTROLLER_TIMEOUT_EN
          else if (ACC_H_OUT_ENABLE) begin
            tmo <= '0;
          end else if (tmo == TMO_LAST) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            tmo <= tmo + 32'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign CTRL_BUSY         = busy;
  assign CTRL_DONE         = done;
  assign CTRL_ERROR        = error;
  assign DST_VALID         = dst_valid;
  assign DST_DATA          = dst_data;
  assign ACC_START         = acc_start;
  assign ACC_W_IN_L_ENABLE = stb.w_l;
  assign ACC_W_IN_X_ENABLE = stb.w_x;
  assign ACC_B_IN_ENABLE   = stb.b;
  assign ACC_X_IN_ENABLE   = stb.x;
  assign ACC_SIZE_X_IN     = size_x;
  assign ACC_SIZE_L_IN     = size_l;
  assign ACC_W_IN          = opnd;
  assign ACC_B_IN          = opnd;
  assign ACC_X_IN          = opnd;

endmodule

// File: doc/ntm_transformer_controller.md
# ntm_transformer_controller

Sequencer that owns the load/run/drain protocol of the transformer accelerator. It takes operands from a single valid/ready source stream and feeds them to the accelerator in this order: W matrix, B vector, X vector. It then pulses START, collects the H_OUT vector onto a result stream, and reports completion. It sits between the NTM host/DMA and the transformer accelerator. K, U and R loading stay outside this block; their enables are tied low at the top level.

## Interface
- DATA_SIZE, 64, width of data and size words
- TIMEOUT_CYCLES, 1024, watchdog limit in RUN (used only with the macro)
- CLK  in  1  single clock, rising edge
- RST  in  1  asynchronous, active-high reset
- CTRL_START  in  1  one-cycle request to begin a job
- CTRL_BUSY  out  1  high from job accept to DONE
- CTRL_DONE  out  1  one-cycle completion pulse
- CTRL_ERROR  out  1  one-cycle pulse: rejected job or timeout
- CFG_SIZE_X, CFG_SIZE_L  in  DATA_SIZE  job dimensions, sampled at accept
- SRC_VALID  in  1, SRC_READY  out  1, SRC_DATA  in  DATA_SIZE  operand stream
- DST_VALID  out  1, DST_DATA  out  DATA_SIZE  result stream, no backpressure
- ACC_START  out  1, ACC_READY  in  1  accelerator run handshake
- ACC_W_IN_L_ENABLE, ACC_W_IN_X_ENABLE, ACC_B_IN_ENABLE, ACC_X_IN_ENABLE  out  1  load strobes
- ACC_SIZE_X_IN, ACC_SIZE_L_IN  out  DATA_SIZE  latched job sizes
- ACC_W_IN, ACC_B_IN, ACC_X_IN  out  DATA_SIZE  registered operand (all three driven from one register)
- ACC_H_OUT_ENABLE  in  1, ACC_H_OUT  in  DATA_SIZE  result beats

## Operation
- FSM states: IDLE, LOAD_W, LOAD_B, LOAD_X, START, RUN.
- IDLE, job accept:
  - CTRL_START with both sizes nonzero: latch sizes, clear counters, set BUSY, go to LOAD_W.
  - Any size zero: pulse ERROR and stay in IDLE.
- A source beat transfers when SRC_VALID && SRC_READY. SRC_READY = 1 only in the LOAD_* states.
- LOAD_W takes SIZE_L×SIZE_X beats, row-major.
  - Every beat asserts W_IN_X_ENABLE.
  - The last beat of each row (x = SIZE_X−1) also asserts W_IN_L_ENABLE.
  - The x counter wraps to 0 and l increments at row end.
  - The final beat (l = SIZE_L−1, x = SIZE_X−1) moves the FSM to LOAD_B.
- LOAD_B takes SIZE_L beats with B_IN_ENABLE, then the FSM moves to LOAD_X.
- LOAD_X takes SIZE_X beats with X_IN_ENABLE, then the FSM moves to START.
- START lasts one cycle: ACC_START = 1, h counter cleared, then the FSM moves to RUN.
- RUN:
  - Each ACC_H_OUT_ENABLE beat with h < SIZE_L is forwarded to DST and increments h.
  - Beats with h ≥ SIZE_L are dropped.
  - A sticky flag records ACC_READY.
  - When the flag is set and h = SIZE_L: pulse DONE, clear BUSY, return to IDLE.
- CTRL_START is ignored while BUSY.
- Counter and size arithmetic is unsigned DATA_SIZE. Comparisons use the latched sizes only; CFG changes during a job have no effect.

## Timing
- Reset values: all outputs 0, FSM = IDLE, counters 0.
- RST mid-job aborts immediately. No DONE or ERROR is generated for the aborted job.
- Load latency: a beat transferred in cycle n produces the strobe and ACC_*_IN data in cycle n+1 (registered). Strobes are single-cycle per beat. Idle source cycles produce no strobe.
- Accept is visible as BUSY one cycle after CTRL_START.
- A RUN beat in cycle n produces DST_VALID/DST_DATA in cycle n+1.
- If ACC_READY and the final H beat coincide, DONE is asserted the next cycle.
- ACC_READY seen before any H beat is held in the sticky flag. DONE waits for SIZE_L beats.

## Configuration
- Macro: NTM_TRANSFORMER_CONTROLLER_TIMEOUT_EN.
- Defined: a RUN cycle counter is cleared on entering RUN and on every H beat. When it reaches TIMEOUT_CYCLES: pulse ERROR, clear BUSY, go to IDLE, no DONE.
- Undefined: no counter. RUN waits indefinitely and ERROR is only produced by zero-size rejection.

## Structure
- Package ntm_transformer_controller_pkg holds:
  - the FSM state enum;
  - the strobe bundle typedef;
  - the TIMEOUT_CYCLES default constant.
- Sub-module ntm_transformer_index_counter: two-level (column/row) counter with wrap and end-of-row/end-of-matrix flags. It is instantiated for LOAD_W and reused with rows = 1 for the LOAD_B and LOAD_X vectors.

## Test plan
- SIZE_X=3, SIZE_L=2, continuous source → 6 W_IN_X_ENABLE pulses, W_IN_L_ENABLE on beats 3 and 6, then 2 B strobes, 3 X strobes, one ACC_START pulse. Two H beats plus READY → 2 DST beats, DONE pulse, BUSY low.
- Same job with SRC_VALID toggling every other cycle → strobe count unchanged, no strobe in idle-source cycles, data order preserved.
- CFG_SIZE_X=0 with CTRL_START → ERROR pulse next cycle, BUSY stays 0, SRC_READY stays 0.
- READY asserted before any H beat, then 3 H beats with SIZE_L=2 → DONE only after beat 2, third beat not forwarded.
- RST asserted during LOAD_X → all outputs 0 immediately. A new 1×1 job afterwards completes normally.
- With the macro and TIMEOUT_CYCLES=16, no H beats or READY in RUN → ERROR on RUN cycle 16, no DONE. Without the macro the bench observes BUSY held for 100 cycles.
